// File: rtl/lsu_stage.sv
// Load/store stage between EXU and WBU: one word-aligned memory request per instruction,
// raw lane-shifted read data to WBU. Optional misalignment trap: LSU_MISALIGN_CHECK_EN.
module lsu_stage #(
    parameter int unsigned SIDE_W = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_out_i,
    input  logic [31:0]       store_data_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [2:0]        func3_i,
    input  logic [SIDE_W-1:0] side_i,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       mem_addr,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       alu_out_o,
    output logic [2:0]        func3_o,
    output logic              MemRead_o,
    output logic [31:0]       mem_rdata_o,
    output logic [SIDE_W-1:0] side_o,
    output logic              err_o,
    output logic              processing
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  off;
    logic        is_mem;
    logic        misalign;
    logic [3:0]  wmask_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] rdata_shift;

    assign off    = alu_out_i[1:0];
    assign is_mem = MemRead_i | MemWrite_i;

    // Store lane placement; shifted masks/data truncate to the bus width.
    always_comb begin
        wmask_nxt = 4'b1111;
        wdata_nxt = store_data_i;
        case (func3_i[1:0])
            2'b00: begin
                wmask_nxt = 4'(4'b0001 << off);
                wdata_nxt = 32'(store_data_i << {off, 3'b000});
            end
            2'b01: begin
                wmask_nxt = 4'(4'b0011 << off);
                wdata_nxt = 32'(store_data_i << {off, 3'b000});
            end
            default: begin
                wmask_nxt = 4'b1111;
                wdata_nxt = store_data_i;
            end
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = is_mem & (((func3_i[1:0] == 2'b01) && (off == 2'd3)) ||
                                ((func3_i[1:0] == 2'b10) && (off != 2'd0)));
`else
    assign misalign = 1'b0;
`endif

    assign rdata_shift = mem_rdata >> {alu_out_o[1:0], 3'b000};

    // Control FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            out_valid     <= 1'b0;
            alu_out_o     <= '0;
            func3_o       <= '0;
            MemRead_o     <= 1'b0;
            mem_rdata_o   <= '0;
            side_o        <= '0;
            err_o         <= 1'b0;
            processing    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready    <= 1'b0;
                        processing  <= 1'b1;
                        alu_out_o   <= alu_out_i;
                        func3_o     <= func3_i;
                        MemRead_o   <= MemRead_i & ~misalign;
                        side_o      <= side_i;
                        mem_rdata_o <= '0;
                        err_o       <= misalign;
                        mem_addr    <= {alu_out_i[31:2], 2'b00};
                        mem_wen     <= MemWrite_i & ~MemRead_i;
                        mem_wdata   <= wdata_nxt;
                        mem_wmask   <= wmask_nxt;
                        if (is_mem && !misalign) begin
                            state         <= S_REQ;
                            mem_req_valid <= 1'b1;
                        end else begin
                            state     <= S_OUT;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_rsp_valid) begin
                            state     <= S_OUT;
                            out_valid <= 1'b1;
                            err_o     <= mem_rsp_err;
                            if (MemRead_o) mem_rdata_o <= rdata_shift;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                        err_o     <= mem_rsp_err;
                        if (MemRead_o) mem_rdata_o <= rdata_shift;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state      <= S_IDLE;
                        out_valid  <= 1'b0;
                        processing <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed scoreboard bench for lsu_stage; build with +define+LSU_MISALIGN_CHECK_EN for the trap variant.
module tb_lsu_stage;

    localparam int unsigned SIDE_W = 200;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       alu_out_i;
    logic [31:0]       store_data_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic [2:0]        func3_i;
    logic [SIDE_W-1:0] side_i;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [31:0]       mem_addr;
    logic              mem_wen;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rdata;
    logic              mem_rsp_err;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       alu_out_o;
    logic [2:0]        func3_o;
    logic              MemRead_o;
    logic [31:0]       mem_rdata_o;
    logic [SIDE_W-1:0] side_o;
    logic              err_o;
    logic              processing;

    lsu_stage #(.SIDE_W(SIDE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out_i(alu_out_i), .store_data_i(store_data_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .func3_i(func3_i), .side_i(side_i),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out_o(alu_out_o), .func3_o(func3_o), .MemRead_o(MemRead_o),
        .mem_rdata_o(mem_rdata_o), .side_o(side_o),
        .err_o(err_o), .processing(processing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       alu;
        logic [2:0]        f3;
        logic              rd;
        logic [31:0]       rdata;
        logic              err;
        logic [SIDE_W-1:0] side;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [SIDE_W-1:0] side_pat(input logic [31:0] seed);
        logic [31:0] w;
        w = seed * 32'h9E37_79B9;
        return SIDE_W'({w, ~w, w ^ 32'h5A5A_5A5A, w, ~w, w, seed, w});
    endfunction

    task automatic push_exp(input logic [31:0] alu, input logic [2:0] f3, input logic rd,
                            input logic [31:0] rdata, input logic err, input logic [SIDE_W-1:0] side);
        exp_t e;
        e.alu = alu; e.f3 = f3; e.rd = rd; e.rdata = rdata; e.err = err; e.side = side;
        sb.push_back(e);
    endtask

    // One accept: drives for one cycle, returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] alu, input logic [31:0] data, input logic rd,
                        input logic wr, input logic [2:0] f3, input logic [SIDE_W-1:0] side);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("send_in_ready", 64'(in_ready), 64'd1);
        alu_out_i = alu; store_data_i = data; MemRead_i = rd; MemWrite_i = wr;
        func3_i = f3; side_i = side; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Request acceptance after wait_req cycles; response wait_rsp cycles after acceptance.
    task automatic mem_phase(input int wait_req, input int wait_rsp,
                             input logic [31:0] rdata, input logic err);
        repeat (wait_req) @(negedge clk);
        mem_req_ready = 1'b1;
        if (wait_rsp == 0) begin
            mem_rsp_valid = 1'b1; mem_rdata = rdata; mem_rsp_err = err;
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        if (wait_rsp > 0) begin
            chk("req_dropped", 64'(mem_req_valid), 64'd0);
            repeat (wait_rsp - 1) @(negedge clk);
            mem_rsp_valid = 1'b1; mem_rdata = rdata; mem_rsp_err = err;
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        end
    endtask

    task automatic expect_out(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_alu"},   64'(alu_out_o),   64'(e.alu));
            chk({tag, "_func3"}, 64'(func3_o),     64'(e.f3));
            chk({tag, "_memrd"}, 64'(MemRead_o),   64'(e.rd));
            chk({tag, "_rdata"}, 64'(mem_rdata_o), 64'(e.rdata));
            chk({tag, "_err"},   64'(err_o),       64'(e.err));
            chk({tag, "_side"},  64'(side_o[63:0]), 64'(e.side[63:0]));
            chk({tag, "_side_full"}, 64'(side_o === e.side), 64'd1);
        end
        chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_released"},  64'(out_valid),  64'd0);
        chk({tag, "_proc_done"}, 64'(processing), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),   64'd1);
    endtask

    initial begin
        logic [SIDE_W-1:0] sd;
        rst_n = 1'b0; in_valid = 1'b0; alu_out_i = '0; store_data_i = '0;
        MemRead_i = 1'b0; MemWrite_i = 1'b0; func3_i = '0; side_i = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),      64'd1);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid),     64'd0);
        chk("rst_proc",      64'(processing),    64'd0);
        chk("rst_alu",       64'(alu_out_o),     64'd0);
        chk("rst_err",       64'(err_o),         64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU pass-through with 1-cycle latency and a 5-cycle WBU stall
        sd = side_pat(32'd1);
        send(32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b111, sd);
        push_exp(32'h0000_1234, 3'b111, 1'b0, 32'h0, 1'b0, sd);
        chk("alu_latency", 64'(out_valid),     64'd1);
        chk("alu_no_req",  64'(mem_req_valid), 64'd0);
        chk("alu_proc",    64'(processing),    64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid",    64'(out_valid), 64'd1);
            chk("stall_alu",      64'(alu_out_o), 64'h1234);
            chk("stall_in_ready", 64'(in_ready),  64'd0);
        end
        expect_out("alu");

        // lb at offset 3, delayed handshake, stray response during REQ ignored
        sd = side_pat(32'd2);
        send(32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'b000, sd);
        push_exp(32'h8000_0003, 3'b000, 1'b1, 32'h0000_00AA, 1'b0, sd);
        chk("lb_req_valid", 64'(mem_req_valid), 64'd1);
        chk("lb_addr",      64'(mem_addr),      64'h8000_0000);
        chk("lb_wen",       64'(mem_wen),       64'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("lb_stray_rsp", 64'(out_valid),     64'd0);
        chk("lb_req_held",  64'(mem_req_valid), 64'd1);
        mem_phase(1, 2, 32'hAABB_CCDD, 1'b0);
        expect_out("lb");

        // sh at offset 2, request and response in the same cycle
        sd = side_pat(32'd3);
        send(32'h0000_0002, 32'h0000_BEEF, 1'b0, 1'b1, 3'b001, sd);
        push_exp(32'h0000_0002, 3'b001, 1'b0, 32'h0, 1'b0, sd);
        chk("sh_wen",   64'(mem_wen),   64'd1);
        chk("sh_wmask", 64'(mem_wmask), 64'b1100);
        chk("sh_wdata", 64'(mem_wdata), 64'hBEEF_0000);
        chk("sh_addr",  64'(mem_addr),  64'h0);
        mem_phase(0, 0, 32'h1234_5678, 1'b0);
        expect_out("sh");

        // sb at offset 1
        sd = side_pat(32'd4);
        send(32'h0000_0101, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, sd);
        push_exp(32'h0000_0101, 3'b000, 1'b0, 32'h0, 1'b0, sd);
        chk("sb_wmask", 64'(mem_wmask), 64'b0010);
        chk("sb_wdata", 64'(mem_wdata), 64'h0000_A500);
        chk("sb_addr",  64'(mem_addr),  64'h100);
        mem_phase(0, 1, 32'h0, 1'b0);
        expect_out("sb");

        // lhu at offset 2 with bus error
        sd = side_pat(32'd5);
        send(32'h0000_0006, 32'h0, 1'b1, 1'b0, 3'b101, sd);
        push_exp(32'h0000_0006, 3'b101, 1'b1, 32'h0000_1122, 1'b1, sd);
        chk("lh_addr", 64'(mem_addr), 64'h4);
        mem_phase(2, 1, 32'h1122_3344, 1'b1);
        expect_out("lh_err");

        // MemRead and MemWrite together behave as a load
        sd = side_pat(32'd6);
        send(32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'b010, sd);
        push_exp(32'h0000_0010, 3'b010, 1'b1, 32'hCAFE_F00D, 1'b0, sd);
        chk("rw_wen", 64'(mem_wen), 64'd0);
        mem_phase(0, 1, 32'hCAFE_F00D, 1'b0);
        expect_out("rw_load");

`ifdef LSU_MISALIGN_CHECK_EN
        sd = side_pat(32'd7);
        send(32'h0000_0006, 32'h1234_5678, 1'b0, 1'b1, 3'b010, sd);
        push_exp(32'h0000_0006, 3'b010, 1'b0, 32'h0, 1'b1, sd);
        chk("sw_mis_no_req", 64'(mem_req_valid), 64'd0);
        expect_out("sw_mis");
        sd = side_pat(32'd8);
        send(32'h0000_0013, 32'h0000_BEEF, 1'b0, 1'b1, 3'b001, sd);
        push_exp(32'h0000_0013, 3'b001, 1'b0, 32'h0, 1'b1, sd);
        chk("sh3_mis_no_req", 64'(mem_req_valid), 64'd0);
        expect_out("sh3_mis");
        sd = side_pat(32'd9);
        send(32'h0000_0005, 32'h0, 1'b1, 1'b0, 3'b010, sd);
        push_exp(32'h0000_0005, 3'b010, 1'b0, 32'h0, 1'b1, sd);
        chk("lw_mis_no_req", 64'(mem_req_valid), 64'd0);
        expect_out("lw_mis");
`else
        sd = side_pat(32'd7);
        send(32'h0000_0006, 32'h1234_5678, 1'b0, 1'b1, 3'b010, sd);
        push_exp(32'h0000_0006, 3'b010, 1'b0, 32'h0, 1'b0, sd);
        chk("sw6_wmask", 64'(mem_wmask), 64'b1111);
        chk("sw6_addr",  64'(mem_addr),  64'h4);
        chk("sw6_wdata", 64'(mem_wdata), 64'h1234_5678);
        mem_phase(0, 1, 32'h0, 1'b0);
        expect_out("sw6");
        sd = side_pat(32'd8);
        send(32'h0000_0013, 32'h0000_BEEF, 1'b0, 1'b1, 3'b001, sd);
        push_exp(32'h0000_0013, 3'b001, 1'b0, 32'h0, 1'b0, sd);
        chk("sh3_wmask", 64'(mem_wmask), 64'b1000);
        chk("sh3_wdata", 64'(mem_wdata), 64'hEF00_0000);
        chk("sh3_addr",  64'(mem_addr),  64'h10);
        mem_phase(0, 0, 32'h0, 1'b0);
        expect_out("sh3");
        sd = side_pat(32'd9);
        send(32'h0000_0005, 32'h0, 1'b1, 1'b0, 3'b010, sd);
        push_exp(32'h0000_0005, 3'b010, 1'b1, 32'h0011_2233, 1'b0, sd);
        chk("lw5_addr", 64'(mem_addr), 64'h4);
        mem_phase(0, 1, 32'h1122_3344, 1'b0);
        expect_out("lw5");
`endif

        // Reset while waiting for a response; the late response must be ignored
        sd = side_pat(32'd10);
        send(32'h0000_0020, 32'h0, 1'b1, 1'b0, 3'b010, sd);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("wait_proc", 64'(processing), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready),      64'd1);
        chk("midrst_proc",     64'(processing),    64'd0);
        chk("midrst_out",      64'(out_valid),     64'd0);
        chk("midrst_alu",      64'(alu_out_o),     64'd0);
        chk("midrst_side",     64'(side_o === '0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA; mem_rsp_err = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        @(negedge clk);
        chk("stale_out",      64'(out_valid),   64'd0);
        chk("stale_in_ready", 64'(in_ready),    64'd1);
        chk("stale_rdata",    64'(mem_rdata_o), 64'd0);
        chk("stale_err",      64'(err_o),       64'd0);
        chk("sb_drained",     64'(sb.size()),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
